// File: rtl/rst_seq_mgr_if.sv
`default_nettype none
// ============================================================================
// Module   : rst_seq_mgr_if
// Brief    : Control and status bundle of the system reset manager:
//            reset requests and watchdog control in, reset outputs out.
// Revision : 1.0 - initial release
// ============================================================================
interface rst_seq_mgr_if #(
  parameter int N_OUT = 3,
  parameter int CNT_W = 16
);
  logic             sw_rst_req;
  logic             wdt_en;
  logic             wdt_kick;
  logic [N_OUT-1:0] rst_out;
  logic             ready;
  logic [1:0]       cause;
  logic [CNT_W-1:0] wdt_cnt;

  // Reset manager side
  modport master (
    input  sw_rst_req, wdt_en, wdt_kick,
    output rst_out, ready, cause, wdt_cnt
  );

  // System side (requesters and reset consumers)
  modport slave (
    output sw_rst_req, wdt_en, wdt_kick,
    input  rst_out, ready, cause, wdt_cnt
  );
endinterface
`default_nettype wire

// File: rtl/rst_seq_mgr.sv
`default_nettype none
// ============================================================================
// Module   : rst_seq_mgr
// Brief    : System reset manager. Synchronises the board reset, stretches
//            it, then releases N_OUT reset channels in a staggered sequence.
//            Re-runs the sequence on a software request or watchdog timeout.
// Revision : 1.0 - initial release
// ============================================================================
module rst_seq_mgr #(
  parameter int N_OUT       = 3,
  parameter int CNT_W       = 16,
  parameter int STRETCH     = 16,
  parameter int STAGGER     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int WDT_TIMEOUT = 1000
) (
  input  logic          clk,
  input  logic          rst_n,
  rst_seq_mgr_if.master bus
);

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_POR = 2'd0;
  localparam logic [1:0] CAUSE_SW  = 2'd1;
  localparam logic [1:0] CAUSE_WDT = 2'd2;

  // The SYNC->HOLD state transition acts as the final synchroniser stage,
  // so only SYNC_STAGES-1 dedicated flops are needed. This makes HOLD entry
  // land exactly SYNC_STAGES edges after rst_n deasserts.
  localparam int                    SYNC_FLOPS   = SYNC_STAGES - 1;
  localparam logic [SYNC_FLOPS-1:0] SYNC_ONE     = SYNC_FLOPS'(1);
  localparam logic [CNT_W-1:0]      STRETCH_LAST = CNT_W'(STRETCH - 1);
  localparam logic [CNT_W-1:0]      WDT_LAST     = CNT_W'(WDT_TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [SYNC_FLOPS-1:0] sync_q;
  logic             sync_done;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [N_OUT-1:0] rst_q, rst_nxt;
  logic             ready_q, ready_nxt;
  logic [1:0]       cause_q, cause_nxt;
  logic [CNT_W-1:0] wdt_q, wdt_nxt;
  logic             wdt_fire;
  int               elapsed;
  logic [N_OUT-1:0] rel_due;

  assign sync_done = sync_q[SYNC_FLOPS-1];

  // Reset deassertion synchroniser: shifts ones in after rst_n rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= (sync_q << 1) | SYNC_ONE;
  end

  // Channels due for release: channel k is due k*STAGGER edges after channel 0
  always_comb begin
    elapsed = (state == RELEASE) ? (int'(cnt) + 1) : 0;
    rel_due = '0;
    for (int k = 0; k < N_OUT; k++) begin
      rel_due[k] = (elapsed >= k * STAGGER);
    end
  end

  // Watchdog expiry: counter at its last value, enabled, and not kicked
  assign wdt_fire = (state == RUN) && bus.wdt_en && !bus.wdt_kick && (wdt_q == WDT_LAST);

  // Next-state and next-output logic for the reset sequence and watchdog
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rst_nxt   = rst_q;
    ready_nxt = ready_q;
    cause_nxt = cause_q;
    wdt_nxt   = '0;
    case (state)
      SYNC: begin
        cnt_nxt = '0;
        if (sync_done) state_nxt = HOLD;
      end
      HOLD: begin
        if (cnt == STRETCH_LAST) begin
          state_nxt = RELEASE;
          cnt_nxt   = '0;
          rst_nxt   = rst_q & ~rel_due;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RELEASE: begin
        if (rst_q == '0) begin
          state_nxt = RUN;
          ready_nxt = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
          rst_nxt = rst_q & ~rel_due;
        end
      end
      RUN: begin
        if (bus.sw_rst_req || wdt_fire) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
          rst_nxt   = '1;
          ready_nxt = 1'b0;
          cause_nxt = bus.sw_rst_req ? CAUSE_SW : CAUSE_WDT;
        end else if (bus.wdt_en && !bus.wdt_kick) begin
          wdt_nxt = wdt_q + 1'b1;
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SYNC;
      cnt     <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      cause_q <= CAUSE_POR;
      wdt_q   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rst_q   <= rst_nxt;
      ready_q <= ready_nxt;
      cause_q <= cause_nxt;
      wdt_q   <= wdt_nxt;
    end
  end

  assign bus.rst_out = rst_q;
  assign bus.ready   = ready_q;
  assign bus.cause   = cause_q;
  assign bus.wdt_cnt = wdt_q;

endmodule
`default_nettype wire

// File: tb/tb_rst_seq_mgr.sv
`default_nettype none
// ============================================================================
// Module   : tb_rst_seq_mgr
// Brief    : Self-checking bench for rst_seq_mgr. Two instances: a 3-channel
//            staggered one with a short watchdog, and a 4-channel unstaggered
//            one. Expected outputs come from a timeline model: each channel's
//            release edge is derived from the edge at which HOLD was entered.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rst_seq_mgr;
  localparam int NA  = 3;
  localparam int SA  = 4;
  localparam int NB  = 4;
  localparam int SB  = 0;
  localparam int STR = 16;
  localparam int SS  = 2;
  localparam int TMO = 100;
  localparam int CW  = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rst_seq_mgr_if #(.N_OUT(NA), .CNT_W(CW)) bus_a ();
  rst_seq_mgr_if #(.N_OUT(NB), .CNT_W(CW)) bus_b ();

  rst_seq_mgr #(.N_OUT(NA), .CNT_W(CW), .STRETCH(STR), .STAGGER(SA),
                .SYNC_STAGES(SS), .WDT_TIMEOUT(TMO))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

  rst_seq_mgr #(.N_OUT(NB), .CNT_W(CW), .STRETCH(STR), .STAGGER(SB),
                .SYNC_STAGES(SS), .WDT_TIMEOUT(1000))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  int errors = 0;
  int checks = 0;

  // Reference timeline: hold_* is the edge number at which HOLD was entered
  // (-1 while waiting for the synchroniser), everything else follows from it.
  int edge_n    = 0;
  int since_por = 0;
  int hold_a    = -1;
  int hold_b    = -1;
  int m_cause   = 0;
  int m_wdt     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rst(input int hold, input int nout, input int stag);
    logic [31:0] r = '0;
    for (int k = 0; k < nout; k++)
      r[k] = !(hold >= 0 && (edge_n - hold) >= STR + k * stag);
    return r;
  endfunction

  function automatic logic [31:0] exp_ready(input int hold, input int nout, input int stag);
    return {31'd0, (hold >= 0 && (edge_n - hold) >= STR + (nout - 1) * stag + 1)};
  endfunction

  task automatic model_edge();
    bit was_run;
    bit tmo;
    edge_n++;
    if (rst_n) begin
      since_por++;
      was_run = (hold_a >= 0) && ((edge_n - 1 - hold_a) >= STR + (NA - 1) * SA + 1);
      if (hold_a < 0 && since_por == SS) hold_a = edge_n;
      if (hold_b < 0 && since_por == SS) hold_b = edge_n;
      if (was_run) begin
        tmo = bus_a.wdt_en && !bus_a.wdt_kick && (m_wdt == TMO - 1);
        if (bus_a.sw_rst_req) begin
          m_cause = 1; hold_a = edge_n; m_wdt = 0;
        end else if (tmo) begin
          m_cause = 2; hold_a = edge_n; m_wdt = 0;
        end else if (bus_a.wdt_en && !bus_a.wdt_kick) begin
          m_wdt++;
        end else begin
          m_wdt = 0;
        end
      end else begin
        m_wdt = 0;
      end
    end
  endtask

  task automatic model_async_reset();
    hold_a = -1; hold_b = -1; m_cause = 0; m_wdt = 0; since_por = 0;
  endtask

  task automatic compare_all();
    check("rst_a",   bus_a.rst_out, exp_rst(hold_a, NA, SA));
    check("ready_a", bus_a.ready,   exp_ready(hold_a, NA, SA));
    check("cause_a", bus_a.cause,   m_cause);
    check("wdt_a",   bus_a.wdt_cnt, m_wdt);
    check("rst_b",   bus_b.rst_out, exp_rst(hold_b, NB, SB));
    check("ready_b", bus_b.ready,   exp_ready(hold_b, NB, SB));
    check("cause_b", bus_b.cause,   0);
    check("wdt_b",   bus_b.wdt_cnt, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Power-on sequence with the absolute edge numbers of the default timing
  task automatic por_phase();
    for (int i = 0; i < 30; i++) begin
      tick();
      if (since_por == 17) check("por17_a", bus_a.rst_out, 3'b111);
      if (since_por == 18) begin
        check("por18_a", bus_a.rst_out, 3'b110);
        check("por18_b", bus_b.rst_out, 4'b0000);
        check("por18_b_ready", bus_b.ready, 0);
      end
      if (since_por == 19) check("por19_b_ready", bus_b.ready, 1);
      if (since_por == 22) check("por22_a", bus_a.rst_out, 3'b100);
      if (since_por == 26) begin
        check("por26_a", bus_a.rst_out, 3'b000);
        check("por26_ready", bus_a.ready, 0);
      end
      if (since_por == 27) begin
        check("por27_ready", bus_a.ready, 1);
        check("por27_cause", bus_a.cause, 0);
      end
    end
  endtask

  task automatic wait_ready(input string tag);
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      if (bus_a.ready) ok = 1;
    end
    check(tag, ok, 1);
  endtask

  initial begin
    int e, f0, fr, ff;
    bit found;
    bit nores_ok;

    bus_a.sw_rst_req = 0; bus_a.wdt_en = 0; bus_a.wdt_kick = 0;
    bus_b.sw_rst_req = 0; bus_b.wdt_en = 0; bus_b.wdt_kick = 0;

    // Reset held: outputs at reset values
    repeat (3) tick();
    check("rst_hold_a", bus_a.rst_out, 3'b111);
    rst_n = 1'b1;
    por_phase();

    // One-cycle software request in RUN, watchdog enabled without kicks
    bus_a.wdt_en = 1;
    bus_a.sw_rst_req = 1;
    tick();
    e = edge_n;
    bus_a.sw_rst_req = 0;
    check("sw_evt_rst", bus_a.rst_out, 3'b111);
    check("sw_evt_ready", bus_a.ready, 0);
    check("sw_evt_cause", bus_a.cause, 1);
    f0 = -1; fr = -1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (f0 < 0 && !bus_a.rst_out[0]) f0 = edge_n;
      if (fr < 0 && bus_a.ready) fr = edge_n;
    end
    check("sw_ch0_delay", f0 - e, 16);
    check("sw_ready_delay", fr - e, 25);

    // Watchdog timeout with no kicks
    ff = -1;
    for (int i = 0; i < 200 && ff < 0; i++) begin
      tick();
      if (!bus_a.ready) ff = edge_n;
    end
    check("wdt_timeout_edge", ff - fr, TMO);
    check("wdt_cause", bus_a.cause, 2);
    check("wdt_evt_rst", bus_a.rst_out, 3'b111);

    // Kicks every 50 cycles keep the system out of reset
    nores_ok = 1;
    for (int i = 0; i < 10000; i++) begin
      bus_a.wdt_kick = (i % 50 == 49);
      tick();
      if (i > 40 && !bus_a.ready) nores_ok = 0;
    end
    bus_a.wdt_kick = 0;
    check("kick_no_reset", nores_ok, 1);

    // Software request on the same edge as a timeout: SW wins
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick();
      if (bus_a.ready && m_wdt == TMO - 1) found = 1;
    end
    check("wait_tmo_window", found, 1);
    bus_a.sw_rst_req = 1;
    tick();
    e = edge_n;
    bus_a.sw_rst_req = 0;
    check("sw_wdt_cause", bus_a.cause, 1);
    check("sw_wdt_rst", bus_a.rst_out, 3'b111);

    // Software request during RELEASE is ignored
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (bus_a.rst_out == 3'b110) found = 1;
    end
    check("wait_release", found, 1);
    tick();
    bus_a.sw_rst_req = 1;
    tick();
    bus_a.sw_rst_req = 0;
    fr = -1;
    for (int i = 0; i < 30 && fr < 0; i++) begin
      tick();
      if (bus_a.ready) fr = edge_n;
    end
    check("rel_sw_ignored", fr - e, 25);
    check("rel_sw_cause", bus_a.cause, 1);

    // Software request held high: sequence repeats each time RUN is reached
    for (int i = 0; i < 60; i++) begin
      bus_a.sw_rst_req = 1;
      tick();
    end
    bus_a.sw_rst_req = 0;

    // Randomised requests, enables and kicks
    for (int i = 0; i < 600; i++) begin
      bus_a.sw_rst_req = ($urandom_range(0, 99) < 2);
      bus_a.wdt_kick   = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 63) == 0) bus_a.wdt_en = ~bus_a.wdt_en;
      tick();
    end
    bus_a.sw_rst_req = 0; bus_a.wdt_kick = 0; bus_a.wdt_en = 0;

    // Asynchronous reset 3 cycles into RELEASE
    wait_ready("wait_run_async");
    bus_a.sw_rst_req = 1;
    tick();
    bus_a.sw_rst_req = 0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (bus_a.rst_out == 3'b110) found = 1;
    end
    check("wait_release_async", found, 1);
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    model_async_reset();
    #1;
    check("async_rst_a", bus_a.rst_out, 3'b111);
    check("async_ready_a", bus_a.ready, 0);
    check("async_cause_a", bus_a.cause, 0);
    check("async_rst_b", bus_b.rst_out, 4'b1111);
    check("async_ready_b", bus_b.ready, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    por_phase();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
